// File: rtl/switch_debounce_pwm_pkg.sv
// Shared defaults for the switch conditioner / PWM slice.
// Pulls board constants from switch_debounce_pwm_defs.vh.
`include "switch_debounce_pwm_defs.vh"
package switch_debounce_pwm_pkg;
   localparam int CLK_HZ = `SDP_CLK_HZ;
   localparam int DEF_DEBOUNCE_CYCLES = `SDP_DEBOUNCE_CYCLES;
   localparam int DEF_PWM_BITS = `SDP_PWM_BITS;
   localparam int DEF_CNT_W = 17;
endpackage

// File: rtl/switch_debounce_pwm_debounce.sv
// One switch channel: 2-flop synchroniser, stability counter,
// debounced level and 1-cycle rise/fall pulses.
// Ports: clk, rst (async high), sw (raw pad),
//   state (debounced), rise, fall (edge pulses).
module switch_debounce
   import switch_debounce_pwm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic clk,
   input  logic rst,
   input  logic sw,
   output logic state,
   output logic rise,
   output logic fall
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic q1;
   logic q2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q1    <= 1'b0;
         q2    <= 1'b0;
         cnt   <= '0;
         state <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         q1   <= sw;
         q2   <= q1;
         rise <= 1'b0;
         fall <= 1'b0;
         if (q2 == state) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            // held long enough: accept and pulse on the same edge
            state <= q2;
            cnt   <= '0;
            rise  <= q2;
            fall  <= ~q2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: rtl/switch_debounce_pwm_defs.vh
// Default build constants for switch_debounce_pwm.
// 12 MHz board clock, 10 ms debounce window, 8-bit PWM.
`ifndef SWITCH_DEBOUNCE_PWM_DEFS_VH
`define SWITCH_DEBOUNCE_PWM_DEFS_VH
`define SDP_CLK_HZ 12000000
`define SDP_DEBOUNCE_CYCLES (`SDP_CLK_HZ / 100)
`define SDP_PWM_BITS 8
`endif

// File: rtl/switch_debounce_pwm.sv
// Multi-channel switch debouncer plus per-channel LED PWM.
// Ports: CLK12, RESET (async high), SW, DUTY (packed per channel),
//   SW_STATE, SW_RISE, SW_FALL, PWM_OUT (registered).
// Macro SWITCH_DEBOUNCE_PWM_BREATHE_EN: ramped fade replaces on/off gating.
module switch_debounce_pwm
   import switch_debounce_pwm_pkg::*;
#(
   parameter int NUM_CH = 3,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int CNT_W = DEF_CNT_W,
   parameter int PWM_BITS = DEF_PWM_BITS
) (
   input  logic                       CLK12,
   input  logic                       RESET,
   input  logic [NUM_CH-1:0]          SW,
   input  logic [NUM_CH*PWM_BITS-1:0] DUTY,
   output logic [NUM_CH-1:0]          SW_STATE,
   output logic [NUM_CH-1:0]          SW_RISE,
   output logic [NUM_CH-1:0]          SW_FALL,
   output logic [NUM_CH-1:0]          PWM_OUT
);
   logic [PWM_BITS-1:0] pc;
   logic [PWM_BITS-1:0] duty_q [NUM_CH];
   logic wrap;

   assign wrap = &pc;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      switch_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W(CNT_W)
      ) u_db (
         .clk(CLK12),
         .rst(RESET),
         .sw(SW[g]),
         .state(SW_STATE[g]),
         .rise(SW_RISE[g]),
         .fall(SW_FALL[g])
      );
   end

   // duty only changes at the period boundary, so no runt pulses
   always_ff @(posedge CLK12 or posedge RESET) begin
      if (RESET) begin
         pc <= '0;
         for (int i = 0; i < NUM_CH; i++) duty_q[i] <= '0;
      end else begin
         pc <= pc + 1'b1;
         if (wrap) begin
            for (int i = 0; i < NUM_CH; i++)
               duty_q[i] <= DUTY[i*PWM_BITS +: PWM_BITS];
         end
      end
   end

`ifdef SWITCH_DEBOUNCE_PWM_BREATHE_EN
   logic [PWM_BITS-1:0] r [NUM_CH];

   // one ramp step per period; clamp wins so a lowered duty takes hold at once
   always_ff @(posedge CLK12 or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NUM_CH; i++) r[i] <= '0;
      end else if (wrap) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (r[i] > duty_q[i])
               r[i] <= duty_q[i];
            else if (SW_STATE[i] && (r[i] < duty_q[i]))
               r[i] <= r[i] + 1'b1;
            else if (!SW_STATE[i] && (r[i] != '0))
               r[i] <= r[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge CLK12 or posedge RESET) begin
      if (RESET) begin
         PWM_OUT <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            PWM_OUT[i] <= (pc < r[i]);
      end
   end
`else
   always_ff @(posedge CLK12 or posedge RESET) begin
      if (RESET) begin
         PWM_OUT <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++)
            PWM_OUT[i] <= SW_STATE[i] & (pc < duty_q[i]);
      end
   end
`endif
endmodule

// File: tb/tb_switch_debounce_pwm.sv
// Randomised bench for switch_debounce_pwm against a behavioural model.
// Small config: 3 channels, 8-cycle debounce, 4-bit PWM.
module tb_switch_debounce_pwm;
   localparam int N = 3;
   localparam int DC = 8;
   localparam int CW = 4;
   localparam int PB = 4;
   localparam int PER = 16;

   logic clk = 1'b0;
   logic rst;
   logic [N-1:0] sw;
   logic [N*PB-1:0] duty;
   logic [N-1:0] st, rise, fall, pwm;

   always #5 clk = ~clk;

   switch_debounce_pwm #(
      .NUM_CH(N),
      .DEBOUNCE_CYCLES(DC),
      .CNT_W(CW),
      .PWM_BITS(PB)
   ) dut (
      .CLK12(clk),
      .RESET(rst),
      .SW(sw),
      .DUTY(duty),
      .SW_STATE(st),
      .SW_RISE(rise),
      .SW_FALL(fall),
      .PWM_OUT(pwm)
   );

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // reference model: run-length of "pad differs from level", seen 2 clocks late
   bit [N-1:0] m_st, m_rise, m_fall, m_pwm;
   int run [N];
   int lvl [N];
   int deff [N];
   int n;
   bit [N-1:0] hist [$];

   function automatic void m_reset();
      m_st = '0; m_rise = '0; m_fall = '0; m_pwm = '0;
      n = 0;
      hist.delete();
      for (int i = 0; i < N; i++) begin
         run[i] = 0; lvl[i] = 0; deff[i] = 0;
      end
   endfunction

   function automatic void m_step();
      int ph;
      bit [N-1:0] s;
      ph = n % PER;
      for (int i = 0; i < N; i++) begin
`ifdef SWITCH_DEBOUNCE_PWM_BREATHE_EN
         m_pwm[i] = (ph < lvl[i]);
`else
         m_pwm[i] = m_st[i] && (ph < deff[i]);
`endif
      end
      if (ph == PER - 1) begin
         for (int i = 0; i < N; i++) begin
`ifdef SWITCH_DEBOUNCE_PWM_BREATHE_EN
            if (lvl[i] > deff[i]) lvl[i] = deff[i];
            else if (m_st[i] && lvl[i] < deff[i]) lvl[i]++;
            else if (!m_st[i] && lvl[i] > 0) lvl[i]--;
`endif
            deff[i] = int'(duty[i*PB +: PB]);
         end
      end
      n++;
      hist.push_back(sw);
      if (hist.size() > 3) void'(hist.pop_front());
      s = (hist.size() == 3) ? hist[0] : '0;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < N; i++) begin
         run[i] = (s[i] != m_st[i]) ? run[i] + 1 : 0;
         if (run[i] == DC) begin
            run[i] = 0;
            m_st[i] = s[i];
            m_rise[i] = s[i];
            m_fall[i] = ~s[i];
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      if (rst) m_reset();
      else m_step();
      #1;
      chk("state", 32'(st), 32'(m_st));
      chk("rise", 32'(rise), 32'(m_rise));
      chk("fall", 32'(fall), 32'(m_fall));
      chk("pwm", 32'(pwm), 32'(m_pwm));
   endtask

   task automatic count_high(input string tag, input int exp);
      int c;
      c = 0;
      repeat (PER) begin
         tick();
         c += int'(pwm[2]);
      end
      chk(tag, 32'(c), 32'(exp));
   endtask

   initial begin
      rst = 1'b1;
      sw = '0;
      duty = '0;
      m_reset();
      repeat (3) tick();
      chk("rst_outs", {st, rise, fall, pwm}, 32'd0);
      rst = 1'b0;

      // clean rising edge on ch0: accepted exactly 10 clocks later
      sw[0] = 1'b1;
      repeat (9) tick();
      chk("st0_early", 32'(st[0]), 32'd0);
      tick();
      chk("st0_at10", 32'(st[0]), 32'd1);
      chk("rise0_at10", 32'(rise[0]), 32'd1);
      tick();
      chk("rise0_1cyc", 32'(rise[0]), 32'd0);

      // short glitches on ch1 must be rejected
      repeat (8) begin
         sw[1] = 1'b1;
         tick();
         sw[1] = 1'b0;
         repeat (4) tick();
      end
      repeat (4) tick();
      chk("glitch_st1", 32'(st[1]), 32'd0);

      // duty on ch2 with switch held on
      sw[2] = 1'b1;
      duty[2*PB +: PB] = 4'd4;
      repeat (300) tick();
      count_high("pwm_d4", 4);
      duty[2*PB +: PB] = 4'd0;
      repeat (300) tick();
      count_high("pwm_d0", 0);
      duty[2*PB +: PB] = 4'd15;
      repeat (300) tick();
      count_high("pwm_d15", 15);

      // mid-period duty change, checked cycle by cycle by the model
      repeat (5) tick();
      duty[2*PB +: PB] = 4'd9;
      repeat (40) tick();

      // random switch chatter and duty updates
      repeat (400) begin
         if ($urandom_range(0, 7) == 0)
            sw[$urandom_range(0, N-1)] ^= 1'b1;
         if ($urandom_range(0, 19) == 0)
            duty = N*PB'($urandom);
         tick();
      end

      // reset mid-run: outputs clear immediately
      rst = 1'b1;
      #1;
      chk("midrst_outs", {st, rise, fall, pwm}, 32'd0);
      repeat (2) tick();
      rst = 1'b0;

      repeat (200) begin
         if ($urandom_range(0, 9) == 0)
            sw[$urandom_range(0, N-1)] ^= 1'b1;
         if ($urandom_range(0, 29) == 0)
            duty = N*PB'($urandom);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
